// File: rtl/key_pkg.sv
// Shared state type, key width and default debounce length for key_capture8.
// The debounce filter is built only when KEY_CAPTURE_DEBOUNCE_EN is defined.
package key_pkg;

  localparam int KEY_W = 8;
  localparam int unsigned DB_CYCLES_DEFAULT = 32'd1000000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } keyState_t;

  // Later (higher) indices overwrite earlier ones, so the top set bit wins.
  function automatic logic [KEY_W-1:0] highestOneHot(input logic [KEY_W-1:0] vec);
    logic [KEY_W-1:0] res;
    res = '0;
    for (int i = 0; i < KEY_W; i++) begin
      if (vec[i]) begin
        res    = '0;
        res[i] = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button bit: two-flop synchronizer followed by an optional debounce filter.
// Filter present only with KEY_CAPTURE_DEBOUNCE_EN; otherwise the level is the synchronized bit.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic iKey,
  output logic oLevel
);

  logic [1:0] sync_r;

  // Two-flop synchronizer for the raw asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], iKey};
    end
  end

`ifdef KEY_CAPTURE_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 32'd1);

  logic [CNT_W-1:0] count_r;
  logic             level_r;

  // The flip happens on the DB_CYCLES-th consecutive mismatching edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
      level_r <= 1'b0;
    end else if (sync_r[1] == level_r) begin
      count_r <= '0;
    end else if (count_r == CNT_LAST) begin
      count_r <= '0;
      level_r <= ~level_r;
    end else begin
      count_r <= count_r + 1'b1;
    end
  end

  assign oLevel = level_r;
`else
  // DB_CYCLES only shapes the filter, which this build leaves out.
  if (DB_CYCLES == 32'd0) begin : gNoFilter
  end

  assign oLevel = sync_r[1];
`endif

endmodule

// File: rtl/key_capture8.sv
// Eight debounced push-buttons feeding a one-hot capture register with ack handshake.
// Debounce filtering is enabled by defining KEY_CAPTURE_DEBOUNCE_EN.
module key_capture8
  import key_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] iKey,
  input  logic             iAck,
  output logic [KEY_W-1:0] oData,
  output logic             oValid
);

  logic [KEY_W-1:0] level_s;
  logic [KEY_W-1:0] levelPrev_r;
  logic [KEY_W-1:0] press_s;
  keyState_t        state_r;

  for (genvar i = 0; i < KEY_W; i++) begin : gKey
    key_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) uDebounce (
      .clk   (clk),
      .rst_n (rst_n),
      .iKey  (iKey[i]),
      .oLevel(level_s[i])
    );
  end

  // Only rising debounced levels count as presses.
  assign press_s = level_s & ~levelPrev_r;

  // Previous debounced levels for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      levelPrev_r <= '0;
    end else begin
      levelPrev_r <= level_s;
    end
  end

  // Capture FSM; presses outside IDLE are simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      oData   <= '0;
      oValid  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|press_s) begin
            oData   <= highestOneHot(press_s);
            oValid  <= 1'b1;
            state_r <= HOLD;
          end
        end
        HOLD: begin
          if (iAck) begin
            oData   <= '0;
            oValid  <= 1'b0;
            state_r <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (level_s == '0) begin
            state_r <= IDLE;
          end
        end
        default: begin
          oData   <= '0;
          oValid  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/key_capture8.md
KEY_CAPTURE8 -- requirements
Module: key_capture8

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 1000000, the number of consecutive stable cycles (10 ms at 100 MHz) needed to accept a key level change.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port iKey, input, 8 bits: raw asynchronous push-buttons, 1 = pressed.
REQ-005 The block SHALL have port iAck, input, 1 bit: consumer acknowledge of the current code.
REQ-006 The block SHALL have port oData, output, 8 bits: one-hot key vector driving the 8-to-3 encoder's iData; all-zero when no key is captured.
REQ-007 The block SHALL have port oValid, output, 1 bit: high while oData holds a captured key.

Function
REQ-008 Each iKey bit SHALL pass through a two-flop synchronizer before any other use.
REQ-009 Each synchronized bit SHALL have its own debouncer: a debounced level plus a counter of width ceil(log2(DB_CYCLES+1)).
REQ-010 A debouncer's counter SHALL clear whenever the synchronized bit equals its debounced level, and SHALL increment otherwise.
REQ-011 When a counter reaches DB_CYCLES, the debounced level SHALL flip on that edge and the counter SHALL clear.
REQ-012 A press event SHALL be a 0->1 transition of a debounced level; 1->0 transitions are not events.
REQ-013 The state machine SHALL have three states: IDLE, HOLD and WAIT_REL.
REQ-014 In IDLE with at least one press event, the block SHALL latch a one-hot vector into oData, set oValid = 1 on the next edge, and enter HOLD.
REQ-015 If several press events occur in the same cycle, the highest-index bit SHALL win, so oData is always strictly one-hot.
REQ-016 In HOLD, oData and oValid SHALL stay stable until iAck = 1 is sampled.
REQ-017 When iAck = 1 is sampled in HOLD, the next edge SHALL set oValid = 0 and oData = 8'h00 and enter WAIT_REL.
REQ-018 In WAIT_REL, the block SHALL return to IDLE on the first edge where all eight debounced levels are 0.
REQ-019 Press events in HOLD or WAIT_REL SHALL be discarded, not queued, including a press in the same cycle as iAck.
REQ-020 iAck in IDLE or WAIT_REL SHALL be ignored.
REQ-021 Latency SHALL be exactly DB_CYCLES+3 rising edges from the first edge at which a stable new level is sampled to oValid = 1, when the block is in IDLE.
REQ-022 A glitch shorter than DB_CYCLES synchronized cycles SHALL produce no event and leave the debounced level unchanged.

Reset
REQ-023 While rst_n = 0, asynchronously: synchronizers, debounced levels, counters, oData and oValid SHALL be 0, and the state SHALL be IDLE.
REQ-024 Reset asserted mid-HOLD or mid-debounce SHALL discard the captured key and any partial count.
REQ-025 After reset releases, a key already held SHALL be treated as a new press once it is debounced.

Configuration
REQ-026 With macro KEY_CAPTURE_DEBOUNCE_EN defined, the debouncers SHALL be built as specified above.
REQ-027 Without KEY_CAPTURE_DEBOUNCE_EN, the debounced level SHALL equal the synchronized bit, no counters SHALL exist, DB_CYCLES SHALL be ignored, and latency SHALL be 3 edges.

Structure
REQ-028 Package key_pkg SHALL hold the state type (IDLE/HOLD/WAIT_REL), the key-width constant 8, and the default DB_CYCLES constant.
REQ-029 Sub-module key_debounce SHALL implement one synchronizer plus debouncer bit.
REQ-030 key_capture8 SHALL instantiate key_debounce 8 times and contain the edge detection, priority selection and state machine.

Verification (bench uses DB_CYCLES = 4)
REQ-031 Bench SHALL check reset: rst_n low with iKey = 8'hFF -> oData = 8'h00 and oValid = 0 immediately and throughout.
REQ-032 Bench SHALL check a single press: iKey = 8'b0000_0100 held -> oValid = 1 and oData = 8'b0000_0100 exactly 7 edges later, holding until iAck; after iAck, oData = 8'h00.
REQ-033 Bench SHALL check a simultaneous press: iKey = 8'b1010_1010 in one cycle -> oData = 8'b1000_0000.
REQ-034 Bench SHALL check glitch rejection: iKey[3] high for 3 cycles, then low -> oValid stays 0.
REQ-035 Bench SHALL check discard and release: iKey[1] pressed while HOLD has bit 6, then iAck -> no second capture until all keys release; pressing iKey[1] again afterwards -> oData = 8'b0000_0010.
REQ-036 Bench SHALL check mid-hold reset: rst_n pulsed low during HOLD -> outputs are 0 asynchronously; a still-held key is recaptured 7 edges after release of reset.
